// File: rtl/decode_pkg.sv
// Shared defaults and types for the decode-stage register scoreboard.
package decode_pkg;
  localparam int SB_DEPTH = 5;
  localparam int SB_CNT_W = 2;

  typedef logic [SB_DEPTH-1:0] reg_idx_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam reg_idx_t REG_ZERO = '0;
  localparam sb_cnt_t  CNT_MAX  = '1;
endpackage

// File: rtl/sb_counter.sv
// One saturating up/down pending-write counter with zero/max status flags.
// The isOne flag exists only when SB_WB_BYPASS_EN is defined.
module sb_counter
  import decode_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic isZero,
  output logic isMax,
`ifdef SB_WB_BYPASS_EN
  output logic isOne,
`endif
  output logic nextNonZero
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             decEff;

  // A writeback against an empty counter never wraps; it only raises err upstream.
  assign decEff = dec && (count != '0);

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    countNext = count;
    if (inc && !decEff && (count != CntMax)) begin
      countNext = count + CntOne;
    end else if (decEff && !inc) begin
      countNext = count - CntOne;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= countNext;
    end
  end

  assign isZero      = (count == '0);
  assign isMax       = (count == CntMax);
  assign nextNonZero = (countNext != '0);
`ifdef SB_WB_BYPASS_EN
  assign isOne       = (count == CntOne);
`endif

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage register hazard scoreboard: per-register pending-write counters gate issue.
// Define SB_WB_BYPASS_EN to waive hazards covered by a same-cycle forwarded writeback.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = SB_DEPTH,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [DEPTH-1:0] Reg1,
  input  logic [DEPTH-1:0] Reg2,
  input  logic             use_reg2,
  input  logic             dst_we,
  input  logic [DEPTH-1:0] dst_reg,
  input  logic             wb_valid,
  input  logic [DEPTH-1:0] wb_reg,
  output logic [((2**DEPTH == WIDTH) ? WIDTH : 2**DEPTH)-1:0] pending_mask,
  output logic             busy,
  output logic             err
);

  localparam int NumRegs = 2**DEPTH;

  logic [NumRegs-1:0] zeroVec;
  logic [NumRegs-1:0] maxVec;
  logic [NumRegs-1:0] nzNext;
`ifdef SB_WB_BYPASS_EN
  logic [NumRegs-1:0] oneVec;
`endif

  logic rd1Hazard;
  logic rd2Hazard;
  logic dstSat;
  logic issueFire;
  logic wbUnderflow;

  // Register 0 is hard-wired idle: never pending, never saturated.
  assign zeroVec[0] = 1'b1;
  assign maxVec[0]  = 1'b0;
  assign nzNext[0]  = 1'b0;
`ifdef SB_WB_BYPASS_EN
  assign oneVec[0]  = 1'b0;
`endif

  for (genvar i = 1; i < NumRegs; i++) begin : g_cnt
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc        (issueFire && dst_we && (dst_reg == DEPTH'(i))),
      .dec        (wb_valid && (wb_reg == DEPTH'(i))),
      .isZero     (zeroVec[i]),
      .isMax      (maxVec[i]),
`ifdef SB_WB_BYPASS_EN
      .isOne      (oneVec[i]),
`endif
      .nextNonZero(nzNext[i])
    );
  end

  always_comb begin
    rd1Hazard = !zeroVec[Reg1];
    rd2Hazard = use_reg2 && !zeroVec[Reg2];
    dstSat    = dst_we && maxVec[dst_reg];
`ifdef SB_WB_BYPASS_EN
    // The last outstanding write is retiring now and its data is forwarded.
    if (wb_valid && (wb_reg == Reg1) && oneVec[Reg1]) rd1Hazard = 1'b0;
    if (wb_valid && (wb_reg == Reg2) && oneVec[Reg2]) rd2Hazard = 1'b0;
    if (wb_valid && (wb_reg == dst_reg))              dstSat    = 1'b0;
`endif
  end

  assign issue_ready = !(rd1Hazard || rd2Hazard || dstSat);
  assign issueFire   = issue_valid && issue_ready;
  assign wbUnderflow = wb_valid && (wb_reg != '0) && zeroVec[wb_reg];

  // NOTE: reset clears every tracking flop so no stale in-flight write survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_mask <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      pending_mask <= nzNext;
      busy         <= |nzNext;
      if (wbUnderflow) err <= 1'b1;
    end
  end

endmodule
